layer_sched: RTL

Table-driven layer scheduler for the CNN inference core. It replaces hard-wired per-layer sequencing with a small programmable layer table. On GO it walks the table and, for each entry, configures and enables exactly one engine (conv, maxp, dense, result), then waits for that engine's STOP. It also ping-pongs the two pixel-RAM regions between layers and raises STOP when the last layer completes.

---
 rtl/layer_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/layer_sched.sv
// Table-driven CNN layer scheduler: walks a programmable layer table, enables one engine per
// layer, waits for that engine's STOP rising edge and ping-pongs the pixel RAM regions.
module layer_sched #(
  parameter int unsigned SIZE_address_pix        = 13,
  parameter int unsigned NUM_LAYERS              = 16,
  parameter int unsigned picture_storage_limit   = 0,
  parameter int unsigned picture_storage_limit_2 = 3136
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfg_addr,
  input  logic [18:0]                   cfg_data,
  input  logic                          GO,
  input  logic                          STOP_conv,
  input  logic                          STOP_maxp,
  input  logic                          STOP_dense,
  input  logic                          STOP_res,
  output logic                          conv_en,
  output logic                          maxp_en,
  output logic                          dense_en,
  output logic                          result_en,
  output logic [4:0]                    matrix,
  output logic [4:0]                    mem,
  output logic [4:0]                    filt,
  output logic                          globmaxp_en,
  output logic                          nozero_dense,
  output logic [SIZE_address_pix-1:0]   memstartp,
  output logic [SIZE_address_pix-1:0]   memstartzap,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  output logic                          busy,
  output logic                          STOP
);

  localparam int unsigned IdxW = $clog2(NUM_LAYERS);
  localparam logic [SIZE_address_pix-1:0] RegionA = SIZE_address_pix'(picture_storage_limit);
  localparam logic [SIZE_address_pix-1:0] RegionB = SIZE_address_pix'(picture_storage_limit_2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StRun, StNext, StFin} state_e;

  state_e                      state_q, state_d;
  logic [18:0]                 table_q [NUM_LAYERS];
  logic [18:0]                 entry;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        pp_q, pp_d;
  logic [1:0]                  op_q, op_d;
  logic                        last_q, last_d;
  logic [3:0]                  en_q, en_d;
  logic [4:0]                  matrix_q, matrix_d, mem_q, mem_d, filt_q, filt_d;
  logic                        glob_q, glob_d;
  logic                        nozero_q, nozero_d;
  logic [SIZE_address_pix-1:0] memp_q, memp_d, memz_q, memz_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [3:0]                  stop_q, stop_in, stop_rise;
  logic                        stop_edge, seq_end;

  // Bit order matches the op encoding: 0 conv, 1 maxp, 2 dense, 3 result.
  assign stop_in   = {STOP_res, STOP_dense, STOP_maxp, STOP_conv};
  assign stop_rise = stop_in & ~stop_q;
  assign stop_edge = stop_rise[op_q];
  assign seq_end   = last_q || (idx_q == LastIdx);
  assign entry     = table_q[idx_q];

  // Layer table; writes are locked out while a sequence is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= '{default: '0};
    end else if (cfg_we && !busy_q) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (GO) state_d = StFetch;
      StFetch: state_d = StRun;
      StRun:   if (stop_edge) state_d = StNext;
      StNext:  state_d = seq_end ? StFin : StFetch;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; everything is registered below.
  always_comb begin
    idx_d    = idx_q;
    pp_d     = pp_q;
    op_d     = op_q;
    last_d   = last_q;
    en_d     = en_q;
    matrix_d = matrix_q;
    mem_d    = mem_q;
    filt_d   = filt_q;
    glob_d   = glob_q;
    nozero_d = nozero_q;
    memp_d   = memp_q;
    memz_d   = memz_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (GO) begin
          idx_d  = '0;
          pp_d   = 1'b0;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      StFetch: begin
        op_d     = entry[18:17];
        matrix_d = entry[16:12];
        mem_d    = entry[11:7];
        filt_d   = entry[6:2];
        glob_d   = entry[1] && (entry[18:17] == 2'd0);
        last_d   = entry[0];
        // Result reads from the region the previous layer wrote, which is the pp-selected one.
        memp_d   = pp_q ? RegionB : RegionA;
        memz_d   = pp_q ? RegionA : RegionB;
        en_d     = 4'b0001 << entry[18:17];
        nozero_d = (entry[18:17] == 2'd2);
      end
      StRun: begin
        if (stop_edge) begin
          en_d     = '0;
          nozero_d = 1'b0;
        end
      end
      StNext: begin
        if (op_q != 2'd3) pp_d = ~pp_q;
        if (!seq_end) idx_d = idx_q + 1'b1;
      end
      StFin: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers, plus the STOP edge-detect copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      pp_q     <= 1'b0;
      op_q     <= 2'd0;
      last_q   <= 1'b0;
      en_q     <= '0;
      matrix_q <= '0;
      mem_q    <= '0;
      filt_q   <= '0;
      glob_q   <= 1'b0;
      nozero_q <= 1'b0;
      memp_q   <= '0;
      memz_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      pp_q     <= pp_d;
      op_q     <= op_d;
      last_q   <= last_d;
      en_q     <= en_d;
      matrix_q <= matrix_d;
      mem_q    <= mem_d;
      filt_q   <= filt_d;
      glob_q   <= glob_d;
      nozero_q <= nozero_d;
      memp_q   <= memp_d;
      memz_q   <= memz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stop_q   <= stop_in;
    end
  end

  assign conv_en      = en_q[0];
  assign maxp_en      = en_q[1];
  assign dense_en     = en_q[2];
  assign result_en    = en_q[3];
  assign matrix       = matrix_q;
  assign mem          = mem_q;
  assign filt         = filt_q;
  assign globmaxp_en  = glob_q;
  assign nozero_dense = nozero_q;
  assign memstartp    = memp_q;
  assign memstartzap  = memz_q;
  assign layer_idx    = idx_q;
  assign busy         = busy_q;
  assign STOP         = done_q;

endmodule
